// File: rtl/adel_imem.sv
// adel instruction memory with a serial program loader.
// Holds the core in reset until a full program is loaded.
module adel_imem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          prog_start,
  input  logic          ser_valid,
  input  logic          ser_data,
  input  logic [15:0]   pc,
  output logic [15:0]   inst,
  output logic          core_nrst,
  output logic          busy,
  output logic          err,
  output logic [AW:0]   prog_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_RUN,
    S_ERR
  } state_e;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [14:0]   shreg_q, shreg_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic          core_nrst_q, core_nrst_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic [15:0]   mem [DEPTH];
  logic [15:0]   word;
  logic [AW:0]   hdr_n;
  logic          hdr_hi_zero;
  logic          shifting;
  logic          done;
  logic          last;
  logic          we;

  // Next-state logic for the loader FSM and datapath
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    wr_ptr_d    = wr_ptr_q;
    prog_len_d  = prog_len_q;
    we          = 1'b0;
    word        = {shreg_q, ser_data};
    hdr_n       = word[AW:0];
    hdr_hi_zero = (word >> (AW + 1)) == 16'd0;
    shifting    = ser_valid &&
                  (state_q == S_HDR || state_q == S_DATA);
    done        = shifting && (bit_cnt_q == 4'd15);
    last        = {1'b0, wr_ptr_q} == (prog_len_q - ONE_W);

    if (prog_start) begin
      state_d    = S_HDR;
      bit_cnt_d  = 4'd0;
      wr_ptr_d   = '0;
      prog_len_d = '0;
    end else if (shifting) begin
      shreg_d   = word[14:0];
      bit_cnt_d = bit_cnt_q + 4'd1;
      if (done) begin
        if (state_q == S_HDR) begin
          if (!hdr_hi_zero || hdr_n == '0 ||
              hdr_n > DEPTH_W) begin
            state_d = S_ERR;
          end else begin
            prog_len_d = hdr_n;
            state_d    = S_DATA;
          end
        end else begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (last) state_d = S_RUN;
        end
      end
    end

    core_nrst_d = state_d == S_RUN;
    busy_d      = state_d == S_HDR || state_d == S_DATA;
    err_d       = state_d == S_ERR;
  end

  // Loader state and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= '0;
      wr_ptr_q    <= '0;
      prog_len_q  <= '0;
      core_nrst_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      wr_ptr_q    <= wr_ptr_d;
      prog_len_q  <= prog_len_d;
      core_nrst_q <= core_nrst_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Program storage; contents survive reset and reloads
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= word;
  end

  // Fetch path; out-of-range or not-running reads halt the core
  always_comb begin
    inst = 16'h0000;
    if (state_q == S_RUN &&
        (pc >> AW) == 16'd0 &&
        pc < 16'(prog_len_q)) begin
      inst = mem[pc[AW-1:0]];
    end
  end

  assign core_nrst = core_nrst_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign prog_len  = prog_len_q;

endmodule

// File: tb/tb_adel_imem.sv
// Directed bench for adel_imem (DEPTH=64).
// Each task drives one scenario and checks inline.
module tb_adel_imem;

  logic        clk = 1'b0;
  logic        nrst;
  logic        prog_start;
  logic        ser_valid;
  logic        ser_data;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        core_nrst;
  logic        busy;
  logic        err;
  logic [6:0]  prog_len;

  int checks = 0;
  int errors = 0;

  adel_imem #(.DEPTH(64)) dut (
    .clk(clk),
    .nrst(nrst),
    .prog_start(prog_start),
    .ser_valid(ser_valid),
    .ser_data(ser_data),
    .pc(pc),
    .inst(inst),
    .core_nrst(core_nrst),
    .busy(busy),
    .err(err),
    .prog_len(prog_len)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) tick();
    ser_valid = 1'b1;
    ser_data  = b;
    tick();
    ser_valid = 1'b0;
    ser_data  = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w,
                           input int nbits,
                           input bit rnd);
    for (int i = 15; i > 15 - nbits; i--)
      send_bit(w[i], rnd ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (inst !== 16'h0 || core_nrst !== 1'b0 || busy !== 1'b0 ||
        err !== 1'b0 || prog_len !== 7'd0) begin
      errors++;
      $display("FAIL reset_vals got inst=%h cn=%b b=%b e=%b len=%0d",
               inst, core_nrst, busy, err, prog_len);
    end
    tick();
    nrst = 1'b1;
    send_word(16'h0003, 16, 1'b0);
    checks++;
    if (busy !== 1'b0 || prog_len !== 7'd0 || core_nrst !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores got b=%b len=%0d cn=%b exp 0 0 0",
               busy, prog_len, core_nrst);
    end
  endtask

  task automatic test_load3();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || core_nrst !== 1'b0) begin
      errors++;
      $display("FAIL load3_hdr got b=%b cn=%b exp 1 0", busy, core_nrst);
    end
    send_word(16'h0003, 16, 1'b0);
    checks++;
    if (prog_len !== 7'd3) begin
      errors++;
      $display("FAIL load3_len got %0d exp 3", prog_len);
    end
    send_word(16'h8401, 16, 1'b0);
    send_word(16'h8402, 16, 1'b0);
    send_word(16'h0000, 15, 1'b0);
    checks++;
    if (core_nrst !== 1'b0) begin
      errors++;
      $display("FAIL load3_early got cn=%b exp 0", core_nrst);
    end
    send_bit(1'b0, 0);
    checks++;
    if (core_nrst !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load3_run got cn=%b b=%b exp 1 0", core_nrst, busy);
    end
    pc = 16'd0; #1;
    checks++;
    if (inst !== 16'h8401) begin
      errors++;
      $display("FAIL load3_pc0 got %h exp 8401", inst);
    end
    pc = 16'd1; #1;
    checks++;
    if (inst !== 16'h8402) begin
      errors++;
      $display("FAIL load3_pc1 got %h exp 8402", inst);
    end
    pc = 16'd2; #1;
    checks++;
    if (inst !== 16'h0000) begin
      errors++;
      $display("FAIL load3_pc2 got %h exp 0000", inst);
    end
    pc = 16'd3; #1;
    checks++;
    if (inst !== 16'h0000) begin
      errors++;
      $display("FAIL load3_pc3 got %h exp 0000", inst);
    end
    pc = 16'd0;
  endtask

  task automatic test_err();
    logic [15:0] hdrs [3];
    hdrs[0] = 16'h0000;
    hdrs[1] = 16'h0041;
    hdrs[2] = 16'h0081;
    for (int k = 0; k < 3; k++) begin
      pulse_start();
      checks++;
      if (err !== 1'b0 || busy !== 1'b1 || prog_len !== 7'd0 ||
          core_nrst !== 1'b0) begin
        errors++;
        $display("FAIL err_restart%0d got e=%b b=%b len=%0d cn=%b",
                 k, err, busy, prog_len, core_nrst);
      end
      send_word(hdrs[k], 16, 1'b0);
      pc = 16'd0; #1;
      checks++;
      if (err !== 1'b1 || core_nrst !== 1'b0 || inst !== 16'h0 ||
          busy !== 1'b0) begin
        errors++;
        $display("FAIL err_hdr%0d got e=%b cn=%b inst=%h b=%b exp 1 0 0 0",
                 k, err, core_nrst, inst, busy);
      end
    end
    send_word(16'h0001, 16, 1'b0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky got e=%b b=%b exp 1 0", err, busy);
    end
  endtask

  task automatic test_full();
    pulse_start();
    send_word(16'h0040, 16, 1'b0);
    for (int i = 0; i < 64; i++) send_word(16'h8000 + 16'(i), 16, 1'b0);
    checks++;
    if (prog_len !== 7'd64 || core_nrst !== 1'b1) begin
      errors++;
      $display("FAIL full_len got len=%0d cn=%b exp 64 1",
               prog_len, core_nrst);
    end
    pc = 16'd63; #1;
    checks++;
    if (inst !== 16'h803F) begin
      errors++;
      $display("FAIL full_pc63 got %h exp 803f", inst);
    end
    pc = 16'd0; #1;
    checks++;
    if (inst !== 16'h8000) begin
      errors++;
      $display("FAIL full_pc0 got %h exp 8000", inst);
    end
    pc = 16'd64; #1;
    checks++;
    if (inst !== 16'h0000) begin
      errors++;
      $display("FAIL full_pc64 got %h exp 0000", inst);
    end
    pc = 16'h1000; #1;
    checks++;
    if (inst !== 16'h0000) begin
      errors++;
      $display("FAIL full_pc1000 got %h exp 0000", inst);
    end
    pc = 16'd0;
  endtask

  task automatic test_gaps();
    pulse_start();
    send_word(16'h0002, 16, 1'b1);
    send_word(16'h1234, 16, 1'b1);
    send_word(16'h5678, 15, 1'b1);
    for (int g = 0; g < 3; g++) tick();
    checks++;
    if (core_nrst !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL gaps_early got cn=%b b=%b exp 0 1", core_nrst, busy);
    end
    send_bit(1'b0, 0);
    checks++;
    if (core_nrst !== 1'b1) begin
      errors++;
      $display("FAIL gaps_edge got cn=%b exp 1", core_nrst);
    end
    pc = 16'd0; #1;
    checks++;
    if (inst !== 16'h1234) begin
      errors++;
      $display("FAIL gaps_pc0 got %h exp 1234", inst);
    end
    pc = 16'd1; #1;
    checks++;
    if (inst !== 16'h5678) begin
      errors++;
      $display("FAIL gaps_pc1 got %h exp 5678", inst);
    end
    pc = 16'd0;
  endtask

  task automatic test_abort();
    pulse_start();
    send_word(16'h0003, 16, 1'b0);
    send_word(16'h1111, 16, 1'b0);
    send_word(16'hFFFF, 9, 1'b0);
    pulse_start();
    checks++;
    if (core_nrst !== 1'b0 || busy !== 1'b1 || prog_len !== 7'd0) begin
      errors++;
      $display("FAIL abort_state got cn=%b b=%b len=%0d exp 0 1 0",
               core_nrst, busy, prog_len);
    end
    send_word(16'h0001, 16, 1'b0);
    send_word(16'hA000, 16, 1'b0);
    pc = 16'd0; #1;
    checks++;
    if (inst !== 16'hA000 || core_nrst !== 1'b1 || prog_len !== 7'd1) begin
      errors++;
      $display("FAIL abort_reload got inst=%h cn=%b len=%0d exp a000 1 1",
               inst, core_nrst, prog_len);
    end
    pc = 16'd1; #1;
    checks++;
    if (inst !== 16'h0000) begin
      errors++;
      $display("FAIL abort_pc1 got %h exp 0000", inst);
    end
    pc = 16'd0;
  endtask

  task automatic test_back_to_back();
    pulse_start();
    send_word(16'h0001, 16, 1'b0);
    send_word(16'h5555, 15, 1'b0);
    prog_start = 1'b1;
    ser_valid  = 1'b1;
    ser_data   = 1'b1;
    tick();
    prog_start = 1'b0;
    ser_valid  = 1'b0;
    ser_data   = 1'b0;
    checks++;
    if (busy !== 1'b1 || core_nrst !== 1'b0 || prog_len !== 7'd0) begin
      errors++;
      $display("FAIL b2b_hdr got b=%b cn=%b len=%0d exp 1 0 0",
               busy, core_nrst, prog_len);
    end
    send_word(16'h0001, 16, 1'b0);
    send_word(16'hBEEF, 16, 1'b0);
    pc = 16'd0; #1;
    checks++;
    if (inst !== 16'hBEEF || core_nrst !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reload got inst=%h cn=%b exp beef 1",
               inst, core_nrst);
    end
  endtask

  task automatic test_nrst_run();
    pc = 16'd0;
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if (inst !== 16'h0 || core_nrst !== 1'b0 || busy !== 1'b0 ||
        err !== 1'b0 || prog_len !== 7'd0) begin
      errors++;
      $display("FAIL nrst_async got inst=%h cn=%b b=%b e=%b len=%0d",
               inst, core_nrst, busy, err, prog_len);
    end
    tick();
    nrst = 1'b1;
    for (int g = 0; g < 4; g++) tick();
    checks++;
    if (inst !== 16'h0 || core_nrst !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nrst_stay got inst=%h cn=%b b=%b exp 0 0 0",
               inst, core_nrst, busy);
    end
  endtask

  initial begin
    nrst       = 1'b0;
    prog_start = 1'b0;
    ser_valid  = 1'b0;
    ser_data   = 1'b0;
    pc         = 16'd0;
    test_reset();
    test_load3();
    test_err();
    test_full();
    test_gaps();
    test_abort();
    test_back_to_back();
    test_nrst_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adel_imem.md
# adel_imem

Instruction memory and serial program loader for the adel core. Holds up to DEPTH 16-bit instruction words and drives the core's `inst` input combinationally from its `pc` output. Words arrive over a one-bit serial link from the pad ring. The block holds the core in reset through `core_nrst` until a complete program has been loaded.

## Interface
- DEPTH, 64: instruction words stored; power of two, 2..256.
- AW, $clog2(DEPTH): word address width.

- clk  in  1  clock.
- nrst  in  1  reset; asynchronous, active-low.
- prog_start  in  1  single-cycle pulse; aborts any activity and begins a new load.
- ser_valid  in  1  `ser_data` is sampled on this cycle.
- ser_data  in  1  serial bit, MSB first.
- pc  in  16  program counter from the core.
- inst  out  16  instruction word to the core.
- core_nrst  out  1  registered active-low reset to the core.
- busy  out  1  high in HDR or DATA state.
- err  out  1  high in ERR state.
- prog_len  out  AW+1  word count of the last accepted header.

## Operation
- States:
  - IDLE: after reset.
  - HDR: collecting the header word.
  - DATA: collecting program words.
  - RUN: program loaded, core running.
  - ERR: bad header.
- Any state, `prog_start`=1: next state HDR. Clear `bit_cnt` and `wr_ptr`. Set `prog_len`=0. Drive `core_nrst` low. `prog_start` has priority over a coincident `ser_valid`; that bit is discarded.
- Shifting: each `ser_valid` cycle in HDR or DATA does `shreg <= {shreg[14:0], ser_data}` and `bit_cnt++` (4 bits). `ser_valid` in IDLE, RUN or ERR is ignored.
- A word completes on the cycle `bit_cnt`==15 and `ser_valid`=1. The completed word is `{shreg[14:0], ser_data}`.
- HDR, word complete: N = word[AW:0]; the upper bits must be 0.
  - N==0, N>DEPTH, or any nonzero upper bit: go to ERR.
  - Otherwise: `prog_len`<=N, go to DATA.
- DATA, word complete: write `mem[wr_ptr]`, then `wr_ptr++`. When `wr_ptr`==N-1 at the write, go to RUN.
- RUN: `core_nrst`=1. Stays in RUN until `prog_start` or `nrst`.
- ERR: `core_nrst`=0, `err`=1. Stays in ERR until `prog_start`.
- Read (combinational):
  - `inst`=16'h0000 when the state is not RUN, or `pc[15:AW]`!=0, or `pc`>=`prog_len`. On the core, 16'h0000 is "beq r0" with offset 0, i.e. a self-loop halt.
  - Otherwise `inst`=`mem[pc[AW-1:0]]`.
- Memory array is not reset. Contents persist across `prog_start` and are overwritten only by DATA writes.

## Timing
- Reset values: `inst`=0, `core_nrst`=0, `busy`=0, `err`=0, `prog_len`=0, state IDLE, `bit_cnt`=0, `wr_ptr`=0.
- `nrst` deassertion alone never starts a load. Only `prog_start` does.
- `core_nrst` is registered. It goes high on the clock edge that enters RUN, i.e. the edge that writes the last word. The core's first fetch, at `pc`=0, happens in the following cycle.
- Memory writes land on the completing edge and are readable combinationally from the next cycle.
- Minimum load time is 16·(N+1) `ser_valid` cycles after `prog_start`. Gaps in `ser_valid` are allowed and stall shifting only.
- `prog_start` mid-word discards the partial word and all of the in-flight load. `core_nrst` falls on the edge after the pulse.
- `nrst` asserted mid-load: the block returns to its reset values immediately, asynchronously.
- `prog_len`=DEPTH is legal. The last write goes to `wr_ptr`=DEPTH-1 and no wrap occurs.
- Back-to-back: `prog_start` in the same cycle as the last data bit wins. The word is not written and the block goes to HDR.

## Test plan
- Load with DEPTH=64: header 0x0003, then words 0x8401, 0x8402, 0x0000. Expect `prog_len`=3 and `core_nrst` rising exactly 64 `ser_valid` cycles after `prog_start`. With `pc`=0/1/2/3, `inst` reads 0x8401/0x8402/0x0000/0x0000.
- Header 0x0000, then a second run with header 0x0041 (65): each goes to ERR with `err`=1, `core_nrst`=0, `inst`=0. A following `prog_start` returns to HDR with `err`=0.
- Full load with header 0x0040: 64 words with values 0x8000+i. With `pc`=63, `inst`=0x803F; with `pc`=64 or 0x1000, `inst`=0.
- `ser_valid` toggling randomly during a 2-word load gives the same memory contents and the same `core_nrst` edge relative to the last valid bit.
- `prog_start` pulsed after 9 bits of data word 1 during a load in progress: `core_nrst` stays 0 and the old contents are kept. Reloading header 0x0001 plus 0xA000 gives `inst`=0xA000 at `pc`=0.
- `nrst` asserted for 1 cycle in RUN: all outputs return to reset values asynchronously. `inst`=0 until a new load completes.
